// File: rtl/spi_stream_master.sv
// spi_stream_master: FIFO-fed SPI transmit master.
// Each frame is {CMD, fifo word}, shifted out MSB first. SCLK comes from a
// programmable divider, and all four CPOL/CPHA modes are supported.
//
// Upstream handshake: in IDLE the block pops only when enable is high and
// fifo_empty is low. fifo_rd_en is a single-cycle strobe in FETCH. The FIFO
// presents the word one cycle later, and LOAD captures it. fifo_empty is not
// looked at in any other state.
module spi_stream_master #(
  parameter int               DATA_W  = 9,
  parameter int               CMD_W   = 4,
  parameter logic [CMD_W-1:0] CMD     = 4'b1010,
  parameter int               CLK_DIV = 2,
  parameter bit               CPOL    = 1'b0,
  parameter bit               CPHA    = 1'b0,
  parameter int               CS_GAP  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        dbg_state
);

  localparam int N     = CMD_W + DATA_W;
  localparam int CNT_W = $clog2(2 * N + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (CS_GAP > 0) ? $clog2(CS_GAP + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] EDGE_LAST = CNT_W'(2 * N - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((CS_GAP > 0) ? CS_GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_TRAIL = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [N-1:0]     r_shift;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_edge;
  logic [GAP_W-1:0] r_gap;
  logic             r_sclk;
  logic             r_mosi;
  logic             r_cs_n;
  logic             r_done;

  logic [N-1:0]     w_frame;
  logic             w_tick;
  logic             w_last_edge;
  logic             w_leading;
  logic             w_advance;

  assign w_frame     = {CMD, fifo_data};
  assign w_tick      = (r_div == DIV_LAST);
  assign w_last_edge = (r_edge == EDGE_LAST);
  // Odd-numbered toggles (edge count still even) move SCLK away from CPOL.
  assign w_leading   = ~r_edge[0];
  // CPHA=0 shifts on trailing edges except the last one.
  // CPHA=1 shifts on every leading edge.
  assign w_advance   = CPHA ? w_leading : (~w_leading & ~w_last_edge);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (enable && !fifo_empty) w_next = S_FETCH;
      S_FETCH: w_next = S_LOAD;
      S_LOAD:  w_next = S_SHIFT;
      S_SHIFT: if (w_tick && w_last_edge) w_next = S_TRAIL;
      S_TRAIL: if (w_tick) w_next = (CS_GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (r_gap == GAP_LAST) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    fifo_rd_en = (r_state == S_FETCH);
    busy       = (r_state != S_IDLE);
    dbg_state  = r_state;
  end

  // Serial datapath: divider, edge counter, shift register and registered pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk  <= CPOL;
      r_mosi  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_done  <= 1'b0;
      r_div   <= '0;
      r_edge  <= '0;
      r_gap   <= '0;
      r_shift <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_LOAD: begin
          r_cs_n <= 1'b0;
          r_div  <= '0;
          r_edge <= '0;
          if (!CPHA) begin
            r_mosi  <= w_frame[N-1];
            r_shift <= w_frame << 1;
          end else begin
            r_mosi  <= 1'b0;
            r_shift <= w_frame;
          end
        end
        S_SHIFT: begin
          if (w_tick) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            r_edge <= r_edge + 1'b1;
            if (w_advance) begin
              r_mosi  <= r_shift[N-1];
              r_shift <= r_shift << 1;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_TRAIL: begin
          if (w_tick) begin
            r_div  <= '0;
            r_cs_n <= 1'b1;
            r_mosi <= 1'b0;
            r_done <= 1'b1;
            r_gap  <= '0;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_GAP: r_gap <= r_gap + 1'b1;
        default: ;
      endcase
    end
  end

  assign sclk       = r_sclk;
  assign mosi       = r_mosi;
  assign cs_n       = r_cs_n;
  assign frame_done = r_done;

endmodule
